// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the systolic result drain.
//   CLOG2_MIN1  - $clog2 with the result floored at 1 bit, used for counter widths
//   bank_aw     - word address width of one output bank (M*M/N1 words)
//   BANK_AW_DEF - bank address width for the default geometry (M=8, N1=4)
//   drain_state_e - drain FSM states (IDLE, DRAIN)
package systolic_pkg;

  function automatic int CLOG2_MIN1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int bank_aw(input int m, input int n1);
    return CLOG2_MIN1((m * m) / n1);
  endfunction

  localparam int M_DEF       = 8;
  localparam int N1_DEF      = 4;
  localparam int BANK_AW_DEF = bank_aw(M_DEF, N1_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/systolic_drain_row.sv
// drain_row: drain logic for one array row / one output bank.
// Accepts the row's result words, de-serialises each N2-word burst into
// column positions (first word = column N2-1, then descending) and registers
// the bank write. Tiles are walked with tc fastest, then tr.
// Optional feature: SYSTOLIC_DRAIN_RELU_EN clamps negative words to zero
// before the output register.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_clear      - clear counters and row_done (start seen while idle)
//   i_en         - drain armed (busy); words are accepted only while high
//   i_valid      - word valid for this row
//   i_data       - result word for this row
//   o_wr_en      - registered bank write enable
//   o_wr_addr    - registered bank word address
//   o_wr_data    - registered bank write data
//   o_row_done   - this row has written its whole bank
module drain_row
  import systolic_pkg::*;
#(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int N2      = 4,
  parameter int M       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_en,
  input  logic                          i_valid,
  input  logic [D_W_ACC-1:0]            i_data,
  output logic                          o_wr_en,
  output logic [bank_aw(M, N1)-1:0]     o_wr_addr,
  output logic [D_W_ACC-1:0]            o_wr_data,
  output logic                          o_row_done
);

  localparam int AW  = bank_aw(M, N1);
  localparam int KW  = CLOG2_MIN1(N2);
  localparam int TCW = CLOG2_MIN1(M / N2);
  localparam int TRW = CLOG2_MIN1(M / N1);

  localparam logic [KW-1:0]  K_LAST  = KW'(N2 - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'((M / N2) - 1);
  localparam logic [TRW-1:0] TR_LAST = TRW'((M / N1) - 1);

  logic [KW-1:0]      r_k;
  logic [TCW-1:0]     r_tc;
  logic [TRW-1:0]     r_tr;
  logic               r_row_done;
  logic               r_wr_en;
  logic [AW-1:0]      r_wr_addr;
  logic [D_W_ACC-1:0] r_wr_data;

  logic               w_accept;
  logic [AW-1:0]      w_addr;
  logic [D_W_ACC-1:0] w_data;

  // A finished row ignores further valid words until the next start.
  assign w_accept = i_en & i_valid & ~r_row_done;

  // Bursts arrive highest column first, so the column offset is N2-1-k.
  assign w_addr = AW'(int'(r_tr) * M + int'(r_tc) * N2 + (N2 - 1) - int'(r_k));

`ifdef SYSTOLIC_DRAIN_RELU_EN
  assign w_data = i_data[D_W_ACC-1] ? '0 : i_data;
`else
  assign w_data = i_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k        <= '0;
      r_tc       <= '0;
      r_tr       <= '0;
      r_row_done <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
      if (i_clear) begin
        r_k        <= '0;
        r_tc       <= '0;
        r_tr       <= '0;
        r_row_done <= 1'b0;
      end else if (w_accept) begin
        if (r_k == K_LAST) begin
          r_k <= '0;
          if (r_tc == TC_LAST) begin
            r_tc <= '0;
            if (r_tr == TR_LAST) begin
              r_tr       <= '0;
              r_row_done <= 1'b1;
            end else begin
              r_tr <= r_tr + TRW'(1);
            end
          end else begin
            r_tc <= r_tc + TCW'(1);
          end
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_row_done = r_row_done;

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: result drain stage behind the systolic array.
// Each of the N1 row streams is de-serialised independently by a drain_row
// instance into its own row-banked output memory (bank x holds matrix rows
// r with r mod N1 = x). The top owns the IDLE/DRAIN FSM, busy and done.
// Handshake: a row word is transferred on any clock edge where valid_D[x]
// and busy are both high and that row has not finished; there is no
// backpressure, the drain always accepts while armed.
// Optional feature: SYSTOLIC_DRAIN_RELU_EN (negative words written as 0).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - one-cycle pulse arming the drain for one MxM product
//   D, valid_D   - per-row result word and valid
//   wr_en_D      - per-bank write enable
//   wr_addr_D    - per-bank word address
//   wr_data_D    - per-bank write data
//   busy         - armed, product not fully drained
//   done         - one-cycle pulse once all M*M words are written
//   o_dbg_state  - current FSM state
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int N2      = 4,
  parameter int M       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [N1-1:0][D_W_ACC-1:0]           D,
  input  logic [N1-1:0]                        valid_D,
  output logic [N1-1:0]                        wr_en_D,
  output logic [N1-1:0][bank_aw(M, N1)-1:0]    wr_addr_D,
  output logic [N1-1:0][D_W_ACC-1:0]           wr_data_D,
  output logic                                 busy,
  output logic                                 done,
  output drain_state_e                         o_dbg_state
);

  drain_state_e r_state;
  drain_state_e w_state_next;
  logic         r_done;
  logic         w_done_next;
  logic         w_clear;
  logic         w_busy;
  logic [N1-1:0] w_row_done;

  assign w_busy = (r_state == DRAIN);

  // row_done is set on the edge the last word is accepted, so seeing all
  // flags set means every final write is already on the outputs; leaving
  // DRAIN on the next edge puts done one cycle after the last write.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = DRAIN;
          w_clear      = 1'b1;
        end
      end
      DRAIN: begin
        if (&w_row_done) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  for (genvar g = 0; g < N1; g++) begin : g_row
    drain_row #(
      .D_W_ACC (D_W_ACC),
      .N1      (N1),
      .N2      (N2),
      .M       (M)
    ) u_row (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_en       (w_busy),
      .i_valid    (valid_D[g]),
      .i_data     (D[g]),
      .o_wr_en    (wr_en_D[g]),
      .o_wr_addr  (wr_addr_D[g]),
      .o_wr_data  (wr_data_D[g]),
      .o_row_done (w_row_done[g])
    );
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: self-checking bench for systolic_drain (default geometry).
// A behavioural model computes, from the count of words each row has had
// accepted, where the next word must land; a compare process checks every
// output on every falling edge. Directed literal expectations in exp_q pin
// the address/data order independently of the model.
module tb_systolic_drain;
  import systolic_pkg::*;

  localparam int D_W_ACC = 16;
  localparam int N1      = 4;
  localparam int N2      = 4;
  localparam int M       = 8;
  localparam int AW      = $clog2(M * M / N1);
  localparam int TOT     = M * M / N1;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           start;
  logic [N1-1:0][D_W_ACC-1:0]     D;
  logic [N1-1:0]                  valid_D;
  logic [N1-1:0]                  wr_en_D;
  logic [N1-1:0][AW-1:0]          wr_addr_D;
  logic [N1-1:0][D_W_ACC-1:0]     wr_data_D;
  logic                           busy;
  logic                           done;
  drain_state_e                   dbg_state;

  logic                 tb_valid [N1];
  logic [D_W_ACC-1:0]   tb_d     [N1];

  always_comb begin
    for (int x = 0; x < N1; x++) begin
      D[x]       = tb_d[x];
      valid_D[x] = tb_valid[x];
    end
  end

  systolic_drain #(.D_W_ACC(D_W_ACC), .N1(N1), .N2(N2), .M(M)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .D           (D),
    .valid_D     (valid_D),
    .wr_en_D     (wr_en_D),
    .wr_addr_D   (wr_addr_D),
    .wr_data_D   (wr_data_D),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_writes = 0;
  int wcount [N1][TOT];
  logic [39:0] exp_q [$];   // {row[7:0], addr[15:0], data[15:0]}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int addr_of(input int j);
    int b;
    b = j / N2;
    return (b / (M / N2)) * M + (b % (M / N2)) * N2 + (N2 - 1 - (j % N2));
  endfunction

  function automatic logic [D_W_ACC-1:0] relu(input logic [D_W_ACC-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    return v[D_W_ACC-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  int                 m_cnt [N1];
  bit                 m_busy;
  bit                 m_rst;
  bit                 m_all_full;
  logic               exp_en   [N1];
  logic [AW-1:0]      exp_addr [N1];
  logic [D_W_ACC-1:0] exp_data [N1];
  logic               exp_busy;
  logic               exp_done;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_rst = 1; exp_busy = 0; exp_done = 0;
      for (int x = 0; x < N1; x++) begin
        m_cnt[x] = 0; exp_en[x] = 0; exp_addr[x] = '0; exp_data[x] = '0;
      end
    end else begin
      m_rst = 0;
      m_all_full = 1;
      for (int x = 0; x < N1; x++) if (m_cnt[x] != TOT) m_all_full = 0;
      exp_done = 0;
      for (int x = 0; x < N1; x++) begin
        if (m_busy && tb_valid[x] && m_cnt[x] < TOT) begin
          exp_en[x]   = 1;
          exp_addr[x] = AW'(addr_of(m_cnt[x]));
          exp_data[x] = relu(tb_d[x]);
          m_cnt[x]++;
        end else begin
          exp_en[x] = 0;
        end
      end
      if (m_busy && m_all_full) begin
        m_busy = 0; exp_done = 1;
      end else if (!m_busy && start) begin
        m_busy = 1;
        for (int x = 0; x < N1; x++) m_cnt[x] = 0;
      end
      exp_busy = m_busy;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int x = 0; x < N1; x++) begin
      chk($sformatf("wr_en[%0d]", x), 32'(wr_en_D[x]), 32'(exp_en[x]));
      if (exp_en[x] || m_rst) begin
        chk($sformatf("wr_addr[%0d]", x), 32'(wr_addr_D[x]), 32'(exp_addr[x]));
        chk($sformatf("wr_data[%0d]", x), 32'(wr_data_D[x]), 32'(exp_data[x]));
      end
      if (wr_en_D[x] === 1'b1) begin
        n_writes++;
        wcount[x][wr_addr_D[x]]++;
        if (exp_q.size() > 0 && exp_q[0][39:32] == 8'(x)) begin
          chk($sformatf("lit_addr[%0d]", x), 32'(wr_addr_D[x]), 32'(exp_q[0][31:16]));
          chk($sformatf("lit_data[%0d]", x), 32'(wr_data_D[x]), 32'(exp_q[0][15:0]));
          void'(exp_q.pop_front());
        end
      end
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (done === 1'b1) n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start = 0;
    for (int x = 0; x < N1; x++) begin tb_valid[x] = 0; tb_d[x] = '0; end
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); rst = 1; idle_inputs();
    repeat (cycles) @(negedge clk);
    rst = 0;
  endtask

  // base < 0 gives random data, otherwise base+j
  task automatic drive_row(input int x, input int skew, input bit gaps, input int n, input int base);
    repeat (skew) begin @(negedge clk); tb_valid[x] = 0; end
    for (int j = 0; j < n; j++) begin
      if (gaps && (j % N2) != 0) begin
        int g;
        g = $urandom_range(2, 0);
        repeat (g) begin @(negedge clk); tb_valid[x] = 0; end
      end
      @(negedge clk);
      tb_valid[x] = 1;
      tb_d[x] = (base < 0) ? D_W_ACC'($urandom) : D_W_ACC'(base + j);
    end
    @(negedge clk); tb_valid[x] = 0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    chk("done_timeout", 32'(c < budget), 32'd1);
  endtask

  task automatic clear_stats();
    n_done = 0; n_writes = 0;
    for (int x = 0; x < N1; x++) for (int a = 0; a < TOT; a++) wcount[x][a] = 0;
  endtask

  task automatic check_coverage(input string tag);
    for (int x = 0; x < N1; x++)
      for (int a = 0; a < TOT; a++)
        chk($sformatf("%s_cover[%0d][%0d]", tag, x, a), 32'(wcount[x][a]), 32'd1);
    chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int lit_addr [16] = '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8, 15, 14, 13, 12};

  initial begin
    rst = 1;
    idle_inputs();
    clear_stats();
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_en", 32'(wr_en_D), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 0;

    // valid while idle must be ignored
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int x = 0; x < N1; x++) begin tb_valid[x] = 1; tb_d[x] = D_W_ACC'($urandom); end
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
    chk("idle_writes", 32'(n_writes), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // single-row ordering with literal addresses and data
    for (int i = 0; i < 16; i++) exp_q.push_back({8'd0, 16'(lit_addr[i]), 16'(100 + i)});
    start_pulse();
    drive_row(0, 0, 0, 16, 100);
    repeat (2) @(negedge clk);
    chk("order_lit_left", 32'(exp_q.size()), 32'd0);
    chk("order_busy_held", 32'(busy), 32'd1);
    do_reset(1);

    // negative / positive words through the data path
`ifdef SYSTOLIC_DRAIN_RELU_EN
    exp_q.push_back({8'd0, 16'd3, 16'h0000});
`else
    exp_q.push_back({8'd0, 16'd3, 16'hFFFE});
`endif
    exp_q.push_back({8'd0, 16'd2, 16'h7FFF});
    start_pulse();
    @(negedge clk); tb_valid[0] = 1; tb_d[0] = 16'hFFFE;
    @(negedge clk); tb_valid[0] = 1; tb_d[0] = 16'h7FFF;
    @(negedge clk); tb_valid[0] = 0;
    repeat (2) @(negedge clk);
    chk("relu_lit_left", 32'(exp_q.size()), 32'd0);
    do_reset(1);

    // full product: skewed rows, random gaps inside bursts
    clear_stats();
    start_pulse();
    for (int x = 0; x < N1; x++) begin
      automatic int xx = x;
      fork drive_row(xx, xx, 1, TOT, -1); join_none
    end
    wait fork;
    wait_done(200);
    repeat (3) @(negedge clk);
    check_coverage("full");

    // simultaneous finish, then extra valid after done
    clear_stats();
    start_pulse();
    for (int x = 0; x < N1; x++) begin
      automatic int xx = x;
      fork drive_row(xx, 0, 0, TOT, -1); join_none
    end
    wait fork;
    wait_done(50);
    @(negedge clk);
    n_writes = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int x = 0; x < N1; x++) begin tb_valid[x] = 1; tb_d[x] = D_W_ACC'($urandom); end
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
    chk("after_done_writes", 32'(n_writes), 32'd0);
    check_coverage("sim");

    // reset mid-drain on row 2, then restart
    start_pulse();
    drive_row(2, 0, 0, 5, 500);
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("midrst_wr_en", 32'(wr_en_D), 32'd0);
    chk("midrst_addr", 32'(wr_addr_D), 32'd0);
    chk("midrst_data", 32'(wr_data_D), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 0;
    exp_q.push_back({8'd2, 16'd3, 16'hABCD});
    start_pulse();
    @(negedge clk); tb_valid[2] = 1; tb_d[2] = 16'hABCD;
    @(negedge clk); tb_valid[2] = 0;
    repeat (2) @(negedge clk);
    chk("restart_lit_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
